// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer.
// Optional retired-instruction counter: define MC_CTRL_PERF_CNT_EN.
module mc_ctrl #(
    parameter logic [2:0] RST_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IR_write,
    output logic        PC_write,
    output logic [1:0]  PC_src,
    output logic        Extend_sel,
    output logic        ALU_src,
    output logic [1:0]  ALU_op,
    output logic        Reg_write,
    output logic        Reg_dst,
    output logic        Mem_to_reg,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_ILL  = 4'd0,
        C_R    = 4'd1,
        C_IMMS = 4'd2,
        C_IMMZ = 4'd3,
        C_LW   = 4'd4,
        C_SW   = 4'd5,
        C_BEQ  = 4'd6,
        C_BNE  = 4'd7,
        C_J    = 4'd8
    } cls_t;

    state_t     state_q, state_d;
    cls_t       cls_q, cls_d;
    logic       ext_q, ext_d;
    logic       src_q, src_d;
    logic [1:0] aluop_q, aluop_d;
    logic       dst_q, dst_d;

    logic       mreq_c, we_c, irw_c, pcw_c;
    logic [1:0] pcs_c;
    logic       regw_c, m2r_c, ill_c;
    logic       retire;
    logic       unused_sig;

    // Opcode classification and the datapath selects each class needs.
    always_comb begin
        cls_d   = C_ILL;
        ext_d   = 1'b0;
        src_d   = 1'b0;
        aluop_d = 2'b00;
        dst_d   = 1'b0;
        case (Op)
            6'b000000: begin
                cls_d = C_R;    aluop_d = 2'b10; dst_d = 1'b1;
            end
            6'b001000, 6'b001001: begin
                cls_d = C_IMMS; ext_d = 1'b1; src_d = 1'b1;
            end
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                cls_d = C_IMMZ; src_d = 1'b1; aluop_d = 2'b11;
            end
            6'b100011: begin
                cls_d = C_LW;   ext_d = 1'b1; src_d = 1'b1;
            end
            6'b101011: begin
                cls_d = C_SW;   ext_d = 1'b1; src_d = 1'b1;
            end
            6'b000100: begin
                cls_d = C_BEQ;  ext_d = 1'b1; aluop_d = 2'b01;
            end
            6'b000101: begin
                cls_d = C_BNE;  ext_d = 1'b1; aluop_d = 2'b01;
            end
            6'b000010: begin
                cls_d = C_J;
            end
            default: cls_d = C_ILL;
        endcase
    end

    // Next state, strobes and retire for the current step.
    always_comb begin
        state_d = state_q;
        mreq_c  = 1'b0;
        we_c    = 1'b0;
        irw_c   = 1'b0;
        pcw_c   = 1'b0;
        pcs_c   = 2'b00;
        regw_c  = 1'b0;
        m2r_c   = 1'b0;
        ill_c   = 1'b0;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mreq_c = 1'b1;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cls_d == C_ILL) begin
                    ill_c   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    C_BEQ, C_BNE: begin
                        if (Zero == (cls_q == C_BEQ)) begin
                            pcw_c = 1'b1;
                            pcs_c = 2'b01;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_J: begin
                        pcw_c   = 1'b1;
                        pcs_c   = 2'b10;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mreq_c = 1'b1;
                we_c   = (cls_q == C_SW);
                if (mem_ready) begin
                    if (cls_q == C_SW) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                regw_c  = 1'b1;
                m2r_c   = (cls_q == C_LW);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register; decode fields are captured only in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_t'(RST_STATE);
            cls_q   <= C_ILL;
            ext_q   <= 1'b0;
            src_q   <= 1'b0;
            aluop_q <= 2'b00;
            dst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q   <= cls_d;
                ext_q   <= ext_d;
                src_q   <= src_d;
                aluop_q <= aluop_d;
                dst_q   <= dst_d;
            end
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cnt_q;

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else if (retire) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign instr_cnt = rst ? 32'd0 : cnt_q;
`else
    assign instr_cnt = 32'd0;
`endif

    // Funct is consumed by the ALU decoder, not here.
    assign unused_sig = ^{Funct, retire};

    assign mem_req    = mreq_c & ~rst;
    assign mem_we     = we_c & ~rst;
    assign IR_write   = irw_c & ~rst;
    assign PC_write   = pcw_c & ~rst;
    assign PC_src     = rst ? 2'b00 : pcs_c;
    assign Reg_write  = regw_c & ~rst;
    assign Mem_to_reg = m2r_c & ~rst;
    assign illegal    = ill_c & ~rst;
    assign Extend_sel = ext_q & ~rst;
    assign ALU_src    = src_q & ~rst;
    assign ALU_op     = rst ? 2'b00 : aluop_q;
    assign Reg_dst    = dst_q & ~rst;
    assign state      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized check of mc_ctrl against a per-instruction
// cycle-list model built from the instruction-class rules.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, mem_we, IR_write, PC_write;
    logic [1:0]  PC_src;
    logic        Extend_sel, ALU_src;
    logic [1:0]  ALU_op;
    logic        Reg_write, Reg_dst, Mem_to_reg, illegal;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .IR_write(IR_write), .PC_write(PC_write), .PC_src(PC_src),
        .Extend_sel(Extend_sel), .ALU_src(ALU_src), .ALU_op(ALU_op),
        .Reg_write(Reg_write), .Reg_dst(Reg_dst), .Mem_to_reg(Mem_to_reg),
        .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [8:0] strb;
        logic       rdy;
        logic [5:0] op;
        logic       z;
        logic       cd;
    } cyc_t;

    cyc_t        q[$];
    int          errs = 0;
    int          checks = 0;
    logic [31:0] cnt = 32'd0;
    logic [4:0]  exp_dec;
    logic        cur_legal;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // 0 R, 1 sign-imm, 2 zero-imm, 3 lw, 4 sw, 5 beq, 6 bne, 7 j, 8 illegal
    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'd0:                    return 0;
            6'd8, 6'd9:              return 1;
            6'd12, 6'd13, 6'd14, 6'd15: return 2;
            6'd35:                   return 3;
            6'd43:                   return 4;
            6'd4:                    return 5;
            6'd5:                    return 6;
            6'd2:                    return 7;
            default:                 return 8;
        endcase
    endfunction

    // {Extend_sel, ALU_src, ALU_op, Reg_dst}
    function automatic logic [4:0] dec_of(input int c);
        logic e, s, d;
        logic [1:0] a;
        e = (c == 1 || c == 3 || c == 4 || c == 5 || c == 6);
        s = (c == 1 || c == 2 || c == 3 || c == 4);
        d = (c == 0);
        a = (c == 0) ? 2'b10 : (c == 2) ? 2'b11 :
            (c == 5 || c == 6) ? 2'b01 : 2'b00;
        return {e, s, a, d};
    endfunction

    function automatic logic [8:0] mk(input logic mr, input logic we,
        input logic irw, input logic pcw, input logic [1:0] ps,
        input logic rw, input logic m2r, input logic il);
        return {mr, we, irw, pcw, ps, rw, m2r, il};
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef MC_CTRL_PERF_CNT_EN
        return cnt;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(63));
    endfunction

    task automatic push(input logic [2:0] st, input logic [8:0] s,
                        input logic rdy, input logic [5:0] op,
                        input logic z, input logic cd);
        cyc_t r;
        r.st = st; r.strb = s; r.rdy = rdy;
        r.op = op; r.z = z; r.cd = cd;
        q.push_back(r);
    endtask

    // Expected cycle list for one instruction with given stall counts.
    task automatic build(input logic [5:0] op, input logic z,
                         input int fs, input int ms);
        int  c;
        logic tk;
        c = cls_of(op);
        q.delete();
        cur_legal = (c != 8);
        for (int i = 0; i < fs; i++)
            push(3'd0, mk(1,0,0,0,2'b00,0,0,0), 1'b0, rop(), rb(), 1'b0);
        push(3'd0, mk(1,0,1,1,2'b00,0,0,0), 1'b1, rop(), rb(), 1'b0);
        push(3'd1, mk(0,0,0,0,2'b00,0,0,c == 8), rb(), op, rb(), 1'b0);
        if (c == 8) return;
        exp_dec = dec_of(c);
        if (c == 5 || c == 6) begin
            tk = (c == 5) ? z : ~z;
            push(3'd2, mk(0,0,0,tk,tk ? 2'b01 : 2'b00,0,0,0),
                 rb(), rop(), z, 1'b1);
        end else if (c == 7) begin
            push(3'd2, mk(0,0,0,1,2'b10,0,0,0), rb(), rop(), rb(), 1'b1);
        end else begin
            push(3'd2, mk(0,0,0,0,2'b00,0,0,0), rb(), rop(), rb(), 1'b1);
            if (c == 3 || c == 4) begin
                for (int i = 0; i < ms; i++)
                    push(3'd3, mk(1,c == 4,0,0,2'b00,0,0,0),
                         1'b0, rop(), rb(), 1'b1);
                push(3'd3, mk(1,c == 4,0,0,2'b00,0,0,0),
                     1'b1, rop(), rb(), 1'b1);
            end
            if (c != 4)
                push(3'd4, mk(0,0,0,0,2'b00,1,c == 3,0),
                     rb(), rop(), rb(), 1'b1);
        end
    endtask

    // Play the first n cycles of the list (all when n < 0).
    task automatic run(input int n);
        int lim;
        lim = (n < 0) ? q.size() : n;
        for (int i = 0; i < lim; i++) begin
            mem_ready = q[i].rdy;
            Op        = q[i].op;
            Zero      = q[i].z;
            Funct     = rop();
            @(negedge clk);
            check("state", {29'd0, state}, {29'd0, q[i].st});
            check("strobes", {23'd0, mem_req, mem_we, IR_write, PC_write,
                  PC_src, Reg_write, Mem_to_reg, illegal},
                  {23'd0, q[i].strb});
            if (q[i].cd)
                check("decode", {27'd0, Extend_sel, ALU_src, ALU_op, Reg_dst},
                      {27'd0, exp_dec});
            check("instr_cnt", instr_cnt, exp_cnt());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(input logic [5:0] op, input logic z,
                         input int fs, input int ms);
        build(op, z, fs, ms);
        run(-1);
        if (cur_legal) cnt = cnt + 32'd1;
    endtask

    function automatic logic [31:0] all_out();
        return {10'd0, mem_req, mem_we, IR_write, PC_write, PC_src,
                Extend_sel, ALU_src, ALU_op, Reg_write, Reg_dst,
                Mem_to_reg, illegal, state, 1'b0, |instr_cnt};
    endfunction

    logic [5:0] legal_ops [12] = '{6'd0, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14,
                                   6'd15, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};

    initial begin
        logic [5:0] op;
        rst = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Op = 6'd8;
        @(negedge clk);
        check("reset_outputs", all_out(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        instr(6'b001000, 1'b0, 0, 0);
        instr(6'b001101, 1'b0, 0, 0);
        instr(6'b100011, 1'b0, 0, 3);
        instr(6'b000100, 1'b1, 0, 0);
        instr(6'b000101, 1'b1, 0, 0);
        instr(6'b000010, 1'b0, 0, 0);
        instr(6'b111111, 1'b0, 0, 0);
        instr(6'b101011, 1'b0, 1, 2);

        build(6'b101011, 1'b0, 0, 5);
        run(4);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("abort_outputs", all_out(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 32'd0;
        instr(6'b001001, 1'b0, 0, 0);

`ifdef MC_CTRL_PERF_CNT_EN
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        cnt = 32'hFFFF_FFFF;
        instr(6'b000000, 1'b0, 0, 0);
        check("cnt_wrap", cnt, 32'd0);
`endif

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(9) == 0) op = rop();
            else op = legal_ops[$urandom_range(11)];
            instr(op, rb(), $urandom_range(2), $urandom_range(3));
        end
        instr(6'b001000, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
